// File: rtl/fetch_pkg.sv
// Shared types and helpers for the Thumb fetch stage: FSM states, condition codes,
// flag positions and the branch target calculation.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold,
    StDrain
  } fetch_state_e;

  localparam logic [3:0] CondAl   = 4'b1110;
  localparam logic [3:0] CondNone = 4'b1111;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  // Unconditional B carries an 11-bit offset, conditional B an 8-bit one.
  function automatic logic [31:0] branch_target(input logic [3:0]  cond,
                                                input logic [31:0] bpc,
                                                input logic [10:0] off_field);
    logic [31:0] off;
    if (cond == CondAl) begin
      off = {{20{off_field[10]}}, off_field, 1'b0};
    end else begin
      off = {{23{off_field[7]}}, off_field[7:0], 1'b0};
    end
    return (bpc + 32'd4 + off) & 32'hFFFF_FFFE;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// ARM condition-code evaluator: decides whether a condition passes for given NZCV flags.
module cond_eval
  import fetch_pkg::*;
(
  input  logic [3:0] flags_i,
  input  logic [3:0] cond_i,
  output logic       taken_o
);

  logic n, z, c, v;

  assign n = flags_i[FlagN];
  assign z = flags_i[FlagZ];
  assign c = flags_i[FlagC];
  assign v = flags_i[FlagV];

  always_comb begin
    taken_o = 1'b0;
    unique case (cond_i)
      4'b0000:  taken_o = z;
      4'b0001:  taken_o = !z;
      4'b0010:  taken_o = c;
      4'b0011:  taken_o = !c;
      4'b0100:  taken_o = n;
      4'b0101:  taken_o = !n;
      4'b0110:  taken_o = v;
      4'b0111:  taken_o = !v;
      4'b1000:  taken_o = c && !z;
      4'b1001:  taken_o = !c || z;
      4'b1010:  taken_o = (n == v);
      4'b1011:  taken_o = (n != v);
      4'b1100:  taken_o = !z && (n == v);
      4'b1101:  taken_o = z || (n != v);
      CondAl:   taken_o = 1'b1;
      CondNone: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Thumb instruction fetch stage: owns the PC, fetches halfwords over req/ack, presents one
// instruction to decode and redirects on taken branches, draining any in-flight request.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instruction,
  output logic        instr_valid,
  output logic [31:0] instr_pc,
  input  logic        stall,
  input  logic        branch_en,
  input  logic [3:0]  branch_cond,
  input  logic [31:0] branch_num,
  input  logic [31:0] branch_pc,
  input  logic [3:0]  flags,
  output logic [31:0] pc,
  output logic        branch_taken
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic [15:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         valid_q, valid_d;
  logic         taken_q, taken_d;

  logic         cond_pass;
  logic         br_take;
  logic [31:0]  target;
  logic         unused_num;

  cond_eval u_cond_eval (
    .flags_i (flags),
    .cond_i  (branch_cond),
    .taken_o (cond_pass)
  );

  assign br_take    = branch_en && cond_pass;
  assign target     = branch_target(branch_cond, branch_pc, branch_num[10:0]);
  assign unused_num = ^branch_num[31:11];

  // A request is only ever raised into a free slot, so an outstanding request always has
  // somewhere to land when it completes.
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = pc_q;
    unique case (state_q)
      StFetch: mem_req = !(valid_q && stall);
      StDrain: begin
        mem_req  = 1'b1;
        mem_addr = drain_addr_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    valid_d      = valid_q;
    taken_d      = 1'b0;

    if (valid_q && !stall) begin
      valid_d = 1'b0;
    end

    // Branch wins over a same-cycle ack; the acked data is simply dropped.
    if (br_take) begin
      pc_d         = target;
      valid_d      = 1'b0;
      taken_d      = 1'b1;
      drain_addr_d = mem_addr;
      state_d      = (mem_req && !mem_ack) ? StDrain : StFetch;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StFetch;
        StFetch: begin
          if (mem_req && mem_ack) begin
            instr_d    = mem_rdata;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + 32'd2;
          end else if (valid_q && stall) begin
            state_d = StHold;
          end
        end
        StHold:  if (!stall) state_d = StFetch;
        StDrain: if (mem_ack) state_d = StFetch;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      instr_q      <= '0;
      instr_pc_q   <= '0;
      valid_q      <= 1'b0;
      taken_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      valid_q      <= valid_d;
      taken_q      <= taken_d;
    end
  end

  assign instruction  = instr_q;
  assign instr_valid  = valid_q;
  assign instr_pc     = instr_pc_q;
  assign pc           = pc_q;
  assign branch_taken = taken_q;

endmodule
